// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage (32-cycle shift-add / restoring divide).
// Define EX_MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_r;
  state_t              state_s;
  logic [CNT_W-1:0]    count_r;
  logic [2:0]          op_r;
  logic                done_r;
  logic [XLEN-1:0]     result_r;

  logic [2*XLEN-1:0]   mcand_r;
  logic [XLEN-1:0]     mplier_r;
  logic                msig_r;
  logic [2*XLEN-1:0]   prod_r;

  logic [XLEN-1:0]     quo_r;
  logic [XLEN-1:0]     dvsr_r;
  logic [XLEN-1:0]     rem_r;
  logic                q_neg_r;
  logic                r_neg_r;

  logic                accept_s;
  logic                div_zero_s;
  logic                ovf_s;
  logic                fast_s;
  logic                a_neg_s;
  logic                b_neg_s;
  logic [XLEN-1:0]     abs1_s;
  logic [XLEN-1:0]     abs2_s;
  logic                op1_sext_s;
  logic [XLEN-1:0]     spec_res_s;
  logic                last_s;
  logic [2*XLEN-1:0]   prod_nx_s;
  logic [XLEN:0]       shifted_s;
  logic                ge_s;
  logic [XLEN-1:0]     rem_nx_s;
  logic [XLEN-1:0]     quo_nx_s;
  logic [XLEN-1:0]     calc_res_s;

  assign accept_s   = (state_r == IDLE) && start && !flush;
  assign div_zero_s = md_op[2] && (operand2 == ZERO);
  assign ovf_s      = md_op[2] && !md_op[0] && (operand1 == MIN_NEG) && (operand2 == ALL_ONES);
  assign a_neg_s    = md_op[2] && !md_op[0] && operand1[XLEN-1];
  assign b_neg_s    = md_op[2] && !md_op[0] && operand2[XLEN-1];
  assign abs1_s     = a_neg_s ? (ZERO - operand1) : operand1;
  assign abs2_s     = b_neg_s ? (ZERO - operand2) : operand2;
  assign op1_sext_s = (md_op == 3'd1) || (md_op == 3'd2);
  assign last_s     = (count_r == CNT_MAX);
  assign done       = done_r;
  assign result     = result_r;

`ifdef EX_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa_s;
  logic [2*XLEN-1:0] fb_s;
  logic [2*XLEN-1:0] fast_prod_s;
  assign fast_s      = !md_op[2];
  assign fa_s        = {{XLEN{op1_sext_s && operand1[XLEN-1]}}, operand1};
  assign fb_s        = {{XLEN{(md_op == 3'd1) && operand2[XLEN-1]}}, operand2};
  assign fast_prod_s = fa_s * fb_s;
`else
  assign fast_s = 1'b0;
`endif

  // Result for operations that complete straight from IDLE.
  always_comb begin
    spec_res_s = ZERO;
    if (div_zero_s) begin
      spec_res_s = md_op[1] ? operand1 : ALL_ONES;
    end else if (ovf_s) begin
      spec_res_s = md_op[1] ? ZERO : MIN_NEG;
    end else begin
`ifdef EX_MULDIV_FAST_MUL_EN
      spec_res_s = (md_op == 3'd0) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
`else
      spec_res_s = ZERO;
`endif
    end
  end

  // One shift-add and one restoring-divide step; the signed multiplier's MSB carries negative weight.
  always_comb begin
    prod_nx_s = prod_r;
    if (mplier_r[0]) begin
      if (last_s && msig_r) begin
        prod_nx_s = prod_r - mcand_r;
      end else begin
        prod_nx_s = prod_r + mcand_r;
      end
    end else begin
      prod_nx_s = prod_r;
    end
    shifted_s = {rem_r, quo_r[XLEN-1]};
    ge_s      = (shifted_s >= {1'b0, dvsr_r});
    rem_nx_s  = ge_s ? (shifted_s[XLEN-1:0] - dvsr_r) : shifted_s[XLEN-1:0];
    quo_nx_s  = {quo_r[XLEN-2:0], ge_s};
  end

  // Final result selection with sign fixup, used on the last CALC edge.
  always_comb begin
    calc_res_s = ZERO;
    if (op_r[2]) begin
      if (op_r[1]) begin
        calc_res_s = r_neg_r ? (ZERO - rem_nx_s) : rem_nx_s;
      end else begin
        calc_res_s = q_neg_r ? (ZERO - quo_nx_s) : quo_nx_s;
      end
    end else begin
      calc_res_s = (op_r == 3'd0) ? prod_nx_s[XLEN-1:0] : prod_nx_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state and stall decode.
  always_comb begin
    state_s = state_r;
    stall   = 1'b0;
    case (state_r)
      IDLE: begin
        stall = accept_s;
        if (accept_s) begin
          state_s = (div_zero_s || ovf_s || fast_s) ? DONE : CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        stall = 1'b1;
        if (flush) begin
          state_s = IDLE;
        end else if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and one-cycle done pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == DONE);
    end
  end

  // Operand capture, iteration registers and result register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_r  <= {CNT_W{1'b0}};
      op_r     <= 3'd0;
      result_r <= ZERO;
      mcand_r  <= {(2*XLEN){1'b0}};
      mplier_r <= ZERO;
      msig_r   <= 1'b0;
      prod_r   <= {(2*XLEN){1'b0}};
      quo_r    <= ZERO;
      dvsr_r   <= ZERO;
      rem_r    <= ZERO;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r     <= md_op;
            count_r  <= {CNT_W{1'b0}};
            mcand_r  <= {{XLEN{op1_sext_s && operand1[XLEN-1]}}, operand1};
            mplier_r <= operand2;
            msig_r   <= (md_op == 3'd1);
            prod_r   <= {(2*XLEN){1'b0}};
            quo_r    <= abs1_s;
            dvsr_r   <= abs2_s;
            rem_r    <= ZERO;
            q_neg_r  <= a_neg_s ^ b_neg_s;
            r_neg_r  <= a_neg_s;
            if (state_s == DONE) begin
              result_r <= spec_res_s;
            end else begin
              result_r <= result_r;
            end
          end else begin
            count_r <= count_r;
          end
        end
        CALC: begin
          if (!flush) begin
            count_r  <= count_r + CNT_W'(1);
            prod_r   <= prod_nx_s;
            mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
            rem_r    <= rem_nx_s;
            quo_r    <= quo_nx_s;
            if (last_s) begin
              result_r <= calc_res_s;
            end else begin
              result_r <= result_r;
            end
          end else begin
            count_r <= count_r;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the decode/execute pipeline register.
- Consumes the registered operand1/operand2 and an M-extension opcode.
- Holds the decode/execute register and upstream stages via `stall` while iterating.
- Returns a 32-bit result to the execute-stage result mux, which feeds the execute/memory register.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- CNT_W, 5, iteration counter width; log2(XLEN).

Ports:
- clk  in  1  clock
- nrst  in  1  async active-low reset
- start  in  1  request; high when the execute-stage instruction is an M-op
- md_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- operand1  in  32  rs1 value, forwarded
- operand2  in  32  rs2 value, forwarded
- flush  in  1  kill the in-flight operation
- stall  out  1  freeze upstream registers
- done  out  1  one-cycle pulse; result valid
- result  out  32  result; held until the next accepted start

Behaviour:
- Clock and reset:
  - Single clock `clk`; reset `nrst` is asynchronous, active-low.
  - Reset forces: state=IDLE, stall=0, done=0, result=0, count=0, all internal operand/accumulator registers 0.
  - Reset mid-operation aborts immediately; no done pulse.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 & flush=0 is accepted. Latch operands and md_op, count=0.
  - Division ops: take absolute values per signedness and record the result sign.
  - Multiply ops: sign-extend per MULH/MULHSU rules into a 64-bit partial-product path.
  - Special case: divide by zero (operand2==0) goes IDLE→DONE directly.
    - DIV/DIVU result=32'hFFFF_FFFF; REM/REMU result=operand1.
  - Special case: signed overflow (DIV/REM, operand1=32'h8000_0000, operand2=32'hFFFF_FFFF) goes IDLE→DONE directly.
    - DIV result=32'h8000_0000; REM result=0.
  - All other accepted starts go IDLE→CALC.
- CALC:
  - One iteration per cycle, count++.
  - Multiply: radix-2 shift-add.
  - Divide: restoring, one quotient bit per cycle.
  - At count==31 go to DONE.
  - Total 32 CALC cycles.
- DONE:
  - done=1 for exactly one cycle; result registered.
  - Multiply: MUL selects product[31:0], others select product[63:32].
  - Divide: quotient/remainder with sign fixup. Quotient negative iff signs differ; remainder takes the dividend's sign.
  - Next state is IDLE unconditionally.
- Latency:
  - Accept at edge T, done at cycle T+33.
  - Special cases: done at T+1.
- stall = (state==IDLE & start & ~flush) | (state==CALC).
  - stall is low in DONE so the pipeline advances with the result.
  - stall is combinational from start.
- start ignored outside IDLE. A start in the DONE cycle is not accepted; it is re-presented by the next instruction in IDLE.
- flush:
  - In CALC: go to IDLE next edge; no done; result keeps its old value.
  - In DONE: done still pulses; the consumer discards it.
  - In IDLE with start: not accepted.
- result changes only on entry to DONE.
- Arithmetic: 64-bit product register. Divider uses a 33-bit remainder to hold the subtract borrow. Sign fixup via two's complement at DONE entry. No X propagation on unused bits.

Optional Feature:
- Macro: EX_MULDIV_FAST_MUL_EN
- Defined:
  - Multiply ops use a single-cycle 64-bit combinational multiply. Accepted MUL* goes IDLE→DONE; done at T+1; stall high only in the accept cycle.
  - Divide path is unchanged.
- Undefined: multiply is iterative with 32 CALC cycles as above; no hardware multiplier is inferred.

Test Plan:
- MUL: operand1=7, operand2=32'hFFFF_FFFD (-3) → result=32'hFFFF_FFEB at T+33, done one cycle, stall high T..T+32.
- MULHU: 32'hFFFF_FFFF × 32'hFFFF_FFFF → 32'hFFFF_FFFE.
- MULH: same operands → 0.
- DIV -7/2 → 32'hFFFF_FFFD (-3); REM -7/2 → 32'hFFFF_FFFF (-1); DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero: DIV 5/0 → 32'hFFFF_FFFF; REMU 5/0 → 5; both done at T+1.
- Overflow: DIV 32'h8000_0000/-1 → 32'h8000_0000; REM → 0; done at T+1.
- Flush at CALC count=10 → IDLE next cycle, no done, result unchanged.
- Reset at count=20 → immediate IDLE, outputs 0; next start completes normally.
- With EX_MULDIV_FAST_MUL_EN: MUL 7×-3 done at T+1 → 32'hFFFF_FFEB.
